// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR output path.
//   fir_acc_t : signed 32-bit filter accumulator sample (Q2.30)
//   fir_smp_t : signed 16-bit requantised sample (Q1.15)
//   fir_req_t : requantiser result (clip flag + sample)
package fir_pkg;

  typedef logic signed [31:0] fir_acc_t;
  typedef logic signed [15:0] fir_smp_t;

  localparam fir_smp_t FIR_SMP_MAX = 16'sh7FFF;
  localparam fir_smp_t FIR_SMP_MIN = 16'sh8000;

  localparam int FIR_SHIFT_DEFAULT = 15;

  typedef struct packed {
    logic     clip;
    fir_smp_t smp;
  } fir_req_t;

endpackage

// File: rtl/fir_req_fifo.sv
// Generic synchronous FIFO, DEPTH x WIDTH, with occupancy count.
// Ports:
//   clk, reset (async, active-low)
//   push, wdata      : write side; ignored when full
//   pop              : read side; ignored when empty
//   rdata            : head entry, forced to 0 when empty
//   count            : occupancy 0..DEPTH
// Storage is not reset; emptiness is tracked by count alone, so a reset
// discards the contents without clearing the array.
module fir_req_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             full;
  logic             empty;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointer wrap is natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fir_output_requantizer.sv
// Requantiser between fir_filter and a 16-bit consumer.
// Rounds (half toward +inf), shifts by SHIFT, saturates to signed 16 bits
// and buffers results in a DEPTH-entry FIFO with AXI-Stream on both sides.
// Ports:
//   clk, reset (async, active-low)
//   s_axis_req_* : 32-bit slave stream (tkeep ignored)
//   m_axis_req_* : 16-bit master stream (tkeep tied to 2'b11)
//   sat_event    : registered pulse, one cycle after a clipped accept
//   sat_count    : clipped-sample counter, saturating at 16'hFFFF
// Build option: define FIR_REQ_SAT_CNT_EN to build the sat_count counter;
// otherwise sat_count is tied to 0.
module fir_output_requantizer
  import fir_pkg::*;
#(
  parameter int SHIFT = FIR_SHIFT_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] s_axis_req_tdata,
  input  logic        s_axis_req_tvalid,
  input  logic        s_axis_req_tlast,
  input  logic [3:0]  s_axis_req_tkeep,
  output logic        s_axis_req_tready,
  output logic [15:0] m_axis_req_tdata,
  output logic        m_axis_req_tvalid,
  output logic        m_axis_req_tlast,
  output logic [1:0]  m_axis_req_tkeep,
  input  logic        m_axis_req_tready,
  output logic        sat_event,
  output logic [15:0] sat_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic signed [32:0] RND_BIAS = 33'sd1 <<< (SHIFT - 1);

  // Widen to 33 bits first so the rounding bias cannot overflow.
  function automatic fir_req_t round_sat(input fir_acc_t acc);
    logic signed [32:0] wide;
    fir_req_t           r;
    wide = 33'(acc);
    wide = wide + RND_BIAS;
    wide = wide >>> SHIFT;
    if (wide > 33'(FIR_SMP_MAX)) begin
      r.clip = 1'b1;
      r.smp  = FIR_SMP_MAX;
    end else if (wide < 33'(FIR_SMP_MIN)) begin
      r.clip = 1'b1;
      r.smp  = FIR_SMP_MIN;
    end else begin
      r.clip = 1'b0;
      r.smp  = wide[15:0];
    end
    return r;
  endfunction

  fir_req_t      req;
  logic          push;
  logic          pop;
  logic [16:0]   head;
  logic [CW-1:0] fifo_count;
  logic          unused_tkeep;

  assign unused_tkeep = ^s_axis_req_tkeep;

  assign req  = round_sat(s_axis_req_tdata);
  assign push = s_axis_req_tvalid && s_axis_req_tready;
  assign pop  = m_axis_req_tvalid && m_axis_req_tready;

  fir_req_fifo #(
    .WIDTH (17),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({s_axis_req_tlast, req.smp}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  // Ready is taken from the registered count only: a pop in the same
  // cycle does not make room for a push.
  assign s_axis_req_tready = (fifo_count != CW'(DEPTH));
  assign m_axis_req_tvalid = (fifo_count != '0);
  assign m_axis_req_tdata  = head[15:0];
  assign m_axis_req_tlast  = head[16];
  assign m_axis_req_tkeep  = 2'b11;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_event <= 1'b0;
    else        sat_event <= push && req.clip;
  end

`ifdef FIR_REQ_SAT_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_count <= '0;
    end else if (push && req.clip && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_output_requantizer.sv
module tb_fir_output_requantizer;

  localparam int SHIFT = 15;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic [3:0]  s_tkeep;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [1:0]  m_tkeep;
  logic        m_tready;
  logic        sat_event;
  logic [15:0] sat_count;

  typedef struct {
    logic [15:0] d;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sat_seen = 0;

  fir_output_requantizer #(.SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_req_tdata  (s_tdata),
    .s_axis_req_tvalid (s_tvalid),
    .s_axis_req_tlast  (s_tlast),
    .s_axis_req_tkeep  (s_tkeep),
    .s_axis_req_tready (s_tready),
    .m_axis_req_tdata  (m_tdata),
    .m_axis_req_tvalid (m_tvalid),
    .m_axis_req_tlast  (m_tlast),
    .m_axis_req_tkeep  (m_tkeep),
    .m_axis_req_tready (m_tready),
    .sat_event         (sat_event),
    .sat_count         (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model(input logic [31:0] d);
    longint v;
    v = longint'($signed(d));
    v = v + (longint'(1) << (SHIFT - 1));
    v = v >>> SHIFT;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output side: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (sat_event === 1'b1) sat_seen++;
      if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(m_tdata), 32'hDEAD_0000);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", 32'(m_tdata), 32'(e.d));
          chk("out_last", 32'(m_tlast), 32'(e.l));
          chk("out_keep", 32'(m_tkeep), 32'd3);
        end
      end
    end
  end

  // Leaves tvalid asserted so consecutive calls stream back-to-back.
  task automatic send_beat(input logic [31:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    s_tdata  = d;
    s_tlast  = l;
    s_tkeep  = 4'($urandom);
    s_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) sb.push_back('{model(d), l});
    chk("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_tvalid) break;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("empty_valid", 32'(m_tvalid), 32'd0);
    chk("empty_data", 32'(m_tdata), 32'd0);
    chk("empty_ready", 32'(s_tready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tkeep  = '0;
    m_tready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tkeep", 32'(m_tkeep), 32'd3);
    chk("rst_sat_event", 32'(sat_event), 32'd0);
    chk("rst_sat_count", 32'(sat_count), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // rounding, no clipping, one-cycle latency
    send_beat(32'h0000_4000, 1'b0);
    chk("lat_valid", 32'(m_tvalid), 32'd1);
    chk("lat_data", 32'(m_tdata), 32'd1);
    send_beat(32'hFFFF_C000, 1'b0);
    chk("lat_data2", 32'(m_tdata), 32'd0);
    send_beat(32'hFFFF_BFFF, 1'b0);
    chk("lat_data3", 32'(m_tdata), 32'hFFFF);
    send_beat(32'h3FFF_8000, 1'b0);
    chk("lat_data4", 32'(m_tdata), 32'h7FFF);
    s_tvalid = 1'b0;
    drain();
    chk("no_sat_pulses", 32'(sat_seen), 32'd0);

    // saturation both ways
    send_beat(32'h4000_0000, 1'b0);
    send_beat(32'h8000_0000, 1'b0);
    s_tvalid = 1'b0;
    drain();
    chk("sat_pulses", 32'(sat_seen), 32'd2);
`ifdef FIR_REQ_SAT_CNT_EN
    chk("sat_count", 32'(sat_count), 32'd2);
`else
    chk("sat_count", 32'(sat_count), 32'd0);
`endif

    // back-pressure: fill, stall, release
    m_tready = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(32'(i) << 15, 1'b0);
    s_tvalid = 1'b0;
    chk("full_ready_low", 32'(s_tready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", 32'(s_tready), 32'd0);
      chk("stall_valid", 32'(m_tvalid), 32'd1);
      chk("stall_data", 32'(m_tdata), 32'd1);
    end
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_beat(32'd5 << 15, 1'b0);
    s_tvalid = 1'b0;
    drain();

    // continuous valid with toggling ready
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          @(posedge clk);
          #1;
          m_tready = ~m_tready;
        end
        m_tready = 1'b1;
      end
      begin
        for (int i = 0; i < 10; i++) send_beat(32'(i * 3 - 10) << 15, 1'b0);
        s_tvalid = 1'b0;
      end
    join
    drain();

    // frame with tlast on third beat
    send_beat(32'd100 << 15, 1'b0);
    send_beat(32'd200 << 15, 1'b0);
    send_beat(32'd300 << 15, 1'b1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    drain();
    chk("sat_pulses_final", 32'(sat_seen), 32'd2);

    // reset mid-stream drops buffered samples
    m_tready = 1'b0;
    send_beat(32'd7 << 15, 1'b0);
    send_beat(32'd8 << 15, 1'b0);
    send_beat(32'd9 << 15, 1'b0);
    s_tvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_tvalid), 32'd0);
    chk("mid_rst_ready", 32'(s_tready), 32'd1);
    chk("mid_rst_data", 32'(m_tdata), 32'd0);
    chk("mid_rst_satcnt", 32'(sat_count), 32'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send_beat(32'h0000_8000, 1'b0);
    chk("post_rst_data", 32'(m_tdata), 32'd1);
    s_tvalid = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
